axil_bram_banked: RTL

Single-clock AXI4-Lite slave fronting `N_BANKS` independent true-dual-port BRAM banks. Each bank has a free-running FPGA-side port. It is the parametrised successor of the single-bank AXI-Lite BRAM bridge, with four additions:
- concurrent read and write requests are arbitrated, so either may arrive at any time;
- writes honour byte strobes;
- FPGA/AXI write collisions are detected and reported;
- accesses to unmapped banks are decode-errored.

It sits between the PS AXI-Lite interconnect and the correlator/accumulator result and coefficient memories.

---
 rtl/axil_pkg.sv | 26 ++
 rtl/bram_tdp_be.sv | 35 +++
 rtl/axil_bram_banked.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the banked AXI-Lite BRAM bridge: response codes,
// FSM state encoding and the address-to-bank decode helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_MEM  = 2'd2,
    RD_RESP = 2'd3
  } axil_state_e;

  // Byte address layout is {bank, word, 2'b00}. Result is wide enough for
  // 16 banks plus headroom, so out-of-range banks compare cleanly.
  function automatic logic [4:0] bank_of(input logic [31:0] addr,
                                         input int          word_bits,
                                         input int          bank_bits);
    logic [31:0] sh;
    sh = addr >> (word_bits + 2);
    return sh[4:0] & 5'((1 << bank_bits) - 1);
  endfunction

endpackage

// File: rtl/bram_tdp_be.sv
// Single-clock true-dual-port RAM. Port A is a full-word read-first port,
// port B is a byte-enabled read-first port. Both ports share one process so
// the array has a single driver; port A's write lands last and wins any overlap.
module bram_tdp_be #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  input  logic                    we_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic                    we_b,
  output logic [DATA_WIDTH-1:0]   dout_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read-first on both ports; byte-masked write on B, full-word write on A.
  always_ff @(posedge clk) begin
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
    if (we_b) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (be_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      end
    end
    if (we_a) mem[addr_a] <= din_a;
  end

endmodule

// File: rtl/axil_bram_banked.sv
// AXI4-Lite slave fronting N_BANKS dual-port BRAM banks. The AXI side owns
// port B of every bank; each bank's port A is a free-running FPGA port.
// Reads and writes are arbitrated round-robin, writes honour strobes,
// same-word FPGA/AXI write collisions drop the AXI write with SLVERR, and
// unmapped banks answer DECERR.
module axil_bram_banked
  import axil_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    N_BANKS    = 4,
  parameter int    BANK_BITS  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                              axi_clock,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH+BANK_BITS+1:0]   s_axil_awaddr,
  input  logic [2:0]                        s_axil_awprot,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [DATA_WIDTH-1:0]             s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [ADDR_WIDTH+BANK_BITS+1:0]   s_axil_araddr,
  input  logic [2:0]                        s_axil_arprot,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [DATA_WIDTH-1:0]             s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  input  logic [N_BANKS*ADDR_WIDTH-1:0]     bram_addr,
  input  logic [N_BANKS*DATA_WIDTH-1:0]     bram_din,
  input  logic [N_BANKS-1:0]                bram_we,
  output logic [N_BANKS*DATA_WIDTH-1:0]     bram_dout,
  output logic [15:0]                       collision_cnt
);

  axil_state_e                        state;
  logic                               last_wr;
  logic [4:0]                         aw_bank, ar_bank, rd_bank;
  logic                               aw_ok, ar_ok, rd_ok;
  logic [ADDR_WIDTH-1:0]              aw_word, ar_word, b_word;
  logic                               wr_cand, rd_cand, grant_wr, grant_rd;
  logic [N_BANKS-1:0]                 coll_vec, b_we;
  logic                               collision;
  logic [N_BANKS-1:0][ADDR_WIDTH-1:0] fpga_addr;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0] fpga_din, fpga_dout, axi_dout;
  logic [DATA_WIDTH-1:0]              rd_word;
  logic                               unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  assign fpga_addr = bram_addr;
  assign fpga_din  = bram_din;
  assign bram_dout = fpga_dout;

  assign aw_bank = bank_of(32'(s_axil_awaddr), ADDR_WIDTH, BANK_BITS);
  assign ar_bank = bank_of(32'(s_axil_araddr), ADDR_WIDTH, BANK_BITS);
  assign aw_ok   = aw_bank < 5'(N_BANKS);
  assign ar_ok   = ar_bank < 5'(N_BANKS);
  assign aw_word = s_axil_awaddr[ADDR_WIDTH+1:2];
  assign ar_word = s_axil_araddr[ADDR_WIDTH+1:2];

  // Round-robin on ties: whichever side was not granted last goes next.
  assign wr_cand  = s_axil_awvalid && s_axil_wvalid;
  assign rd_cand  = s_axil_arvalid;
  assign grant_wr = (state == IDLE) && wr_cand && (!rd_cand || !last_wr);
  assign grant_rd = (state == IDLE) && rd_cand && (!wr_cand ||  last_wr);

  assign s_axil_awready = grant_wr;
  assign s_axil_wready  = grant_wr;
  assign s_axil_arready = grant_rd;

  // Only one grant per cycle, so all banks share the AXI-side word address.
  assign b_word    = grant_wr ? aw_word : ar_word;
  assign collision = |coll_vec;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    assign coll_vec[b] = bram_we[b] && (aw_bank == 5'(b)) && (fpga_addr[b] == aw_word);
    assign b_we[b]     = grant_wr && (aw_bank == 5'(b)) && !coll_vec[b];

    bram_tdp_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
    ) u_bank (
      .clk    (axi_clock),
      .addr_a (fpga_addr[b]),
      .din_a  (fpga_din[b]),
      .we_a   (bram_we[b]),
      .dout_a (fpga_dout[b]),
      .addr_b (b_word),
      .din_b  (s_axil_wdata),
      .be_b   (s_axil_wstrb),
      .we_b   (b_we[b]),
      .dout_b (axi_dout[b])
    );
  end

  // Select the AXI-port read data of the bank latched at read grant.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (rd_bank == 5'(b)) rd_word = axi_dout[b];
    end
  end

  // Transaction FSM with registered response channels.
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_wr       <= 1'b1;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rdata  <= '0;
      collision_cnt <= '0;
      rd_bank       <= '0;
      rd_ok         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            last_wr       <= 1'b1;
            s_axil_bvalid <= 1'b1;
            state         <= WR_RESP;
            if (!aw_ok) begin
              s_axil_bresp <= RESP_DECERR;
            end else if (collision) begin
              s_axil_bresp <= RESP_SLVERR;
              if (collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
            end else begin
              s_axil_bresp <= RESP_OKAY;
            end
          end else if (grant_rd) begin
            last_wr <= 1'b0;
            rd_bank <= ar_bank;
            rd_ok   <= ar_ok;
            state   <= RD_MEM;
          end
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        RD_MEM: begin
          s_axil_rdata  <= rd_ok ? rd_word : '0;
          s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_DECERR;
          s_axil_rvalid <= 1'b1;
          state         <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
